inst_fetcher: RTL and testbench

// - Instruction-fetch stage feeding core_controller: given pc, returns the 32-bit instruction word.
// - Controller drives fetcher_reset low in its FETCH state and waits for fetcher_completed.
// - A direct-mapped, word-granular instruction cache sits in front of the valid/ready memory port.
// - Hits return without a memory request.

---
 rtl/felis_fetch_pkg.sv | 13 +
 rtl/inst_cache_array.sv | 51 +++++
 rtl/inst_fetcher.sv | 126 ++++++++++++
 tb/tb_inst_fetcher.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/felis_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package felis_fetch_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REQ,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/inst_cache_array.sv
// Direct-mapped, one-word-per-entry instruction cache storage.
// Only the valid bits are reset or flushed; tag/data are qualified by valid.
module inst_cache_array
  import felis_fetch_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = WORD_BITS - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_BITS-1:0]  rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [WORD_BITS-1:0]  wr_data
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;

  logic [Entries-1:0]   valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q  [Entries];
  logic [WORD_BITS-1:0] data_q [Entries];

  // Flush overrides a coincident fill.
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_idx] = 1'b1;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction-fetch stage: cached lookup of pc, falling back to a valid/ready memory port.
module inst_fetcher
  import felis_fetch_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetcher_reset,
  input  logic [WORD_BITS-1:0] pc,
  output logic [WORD_BITS-1:0] instruction,
  output logic                 fetcher_completed,
  input  logic                 cache_flush,
  output logic [WORD_BITS-1:0] inst_mem_out_addr,
  output logic                 inst_mem_out_valid,
  input  logic [WORD_BITS-1:0] inst_mem_out_data,
  input  logic                 inst_mem_out_ready,
  output logic [WORD_BITS-1:0] hit_count,
  output logic [WORD_BITS-1:0] miss_count
);

  localparam int unsigned TagBits = WORD_BITS - INDEX_BITS - 2;

  fetch_state_t         state_q, state_d;
  logic [WORD_BITS-3:0] word_addr_q, word_addr_d;
  logic [WORD_BITS-1:0] instruction_q, instruction_d;
  logic [WORD_BITS-1:0] hit_q, hit_d;
  logic [WORD_BITS-1:0] miss_q, miss_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TagBits-1:0]    tag;
  logic                  c_valid;
  logic [TagBits-1:0]    c_tag;
  logic [WORD_BITS-1:0]  c_data;
  logic                  hit;
  logic                  fill;
  logic                  cache_we;
  logic                  unused_pc;

  assign unused_pc = ^pc[1:0];

  assign idx = word_addr_q[INDEX_BITS-1:0];
  assign tag = word_addr_q[WORD_BITS-3:INDEX_BITS];

  inst_cache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TagBits)
  ) u_cache (
    .clk     (clk),
    .rst     (reset),
    .flush   (cache_flush),
    .rd_idx  (idx),
    .rd_valid(c_valid),
    .rd_tag  (c_tag),
    .rd_data (c_data),
    .we      (cache_we),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_data (inst_mem_out_data)
  );

  assign hit = c_valid && (c_tag == tag) && !cache_flush;
  // An abort (fetcher_reset high) in the same cycle as ready discards the transfer.
  assign fill     = (state_q == REQ) && !fetcher_reset && inst_mem_out_ready;
  assign cache_we = fill && !cache_flush;

  always_comb begin
    state_d       = state_q;
    word_addr_d   = word_addr_q;
    instruction_d = instruction_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    if (fetcher_reset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = LOOKUP;
          word_addr_d = pc[WORD_BITS-1:2];
        end
        LOOKUP: begin
          if (hit) begin
            state_d       = DONE;
            instruction_d = c_data;
            hit_d         = hit_q + 32'd1;
          end else begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (fill) begin
            state_d       = DONE;
            instruction_d = inst_mem_out_data;
            miss_d        = miss_q + 32'd1;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      word_addr_q   <= '0;
      instruction_q <= '0;
      hit_q         <= '0;
      miss_q        <= '0;
    end else begin
      state_q       <= state_d;
      word_addr_q   <= word_addr_d;
      instruction_q <= instruction_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
    end
  end

  assign instruction        = instruction_q;
  assign inst_mem_out_addr  = {word_addr_q, 2'b00};
  assign inst_mem_out_valid = (state_q == REQ);
  assign fetcher_completed  = (state_q == DONE);
  assign hit_count          = hit_q;
  assign miss_count         = miss_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: stimulus pushes expected completions, a monitor pops them.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetcher_reset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        fetcher_completed;
  logic        cache_flush;
  logic [31:0] inst_mem_out_addr;
  logic        inst_mem_out_valid;
  logic [31:0] inst_mem_out_data;
  logic        inst_mem_out_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  inst_fetcher #(.INDEX_BITS(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .fetcher_reset     (fetcher_reset),
    .pc                (pc),
    .instruction       (instruction),
    .fetcher_completed (fetcher_completed),
    .cache_flush       (cache_flush),
    .inst_mem_out_addr (inst_mem_out_addr),
    .inst_mem_out_valid(inst_mem_out_valid),
    .inst_mem_out_data (inst_mem_out_data),
    .inst_mem_out_ready(inst_mem_out_ready),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_h  = 0;
  logic [31:0] exp_m  = 0;
  logic        comp_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  // Monitor: every rising completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (fetcher_completed && !comp_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: instruction 0x%08h", instruction);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_instruction", instruction, e.instr);
        check("sb_hit_count", hit_count, e.hits);
        check("sb_miss_count", miss_count, e.misses);
      end
    end
    comp_prev = fetcher_completed;
  end

  // One complete fetch; the memory model asserts ready on the delay-th valid cycle.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int delay,
                          input bit exp_hit, input bit flush_on_ready);
    int edges = 0;
    int vcnt  = 0;
    bit done  = 0;
    exp_t e;
    if (exp_hit) exp_h++;
    else         exp_m++;
    e.instr = d; e.hits = exp_h; e.misses = exp_m;
    sb_q.push_back(e);
    @(negedge clk);
    fetcher_reset = 1'b0;
    pc = a;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      inst_mem_out_ready = 1'b0;
      cache_flush = 1'b0;
      if (fetcher_completed) begin
        done = 1;
      end else if (inst_mem_out_valid) begin
        vcnt++;
        if (vcnt == 1) check("mem_addr", inst_mem_out_addr, {a[31:2], 2'b00});
        if (vcnt == delay) begin
          inst_mem_out_ready = 1'b1;
          inst_mem_out_data  = d;
          cache_flush        = flush_on_ready;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: pc 0x%08h never completed", a);
    end
    check("valid_cycles", 32'(vcnt), exp_hit ? 32'd0 : 32'(delay));
    check("latency_edges", 32'(edges), exp_hit ? 32'd2 : 32'(delay + 2));
    fetcher_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_completed", {31'd0, fetcher_completed}, 32'd0);
    check("idle_instr_held", instruction, d);
  endtask

  // Start a fetch and wait (bounded) until it is waiting on memory.
  task automatic start_until_req(input logic [31:0] a, output bit ok);
    ok = 0;
    @(negedge clk);
    fetcher_reset = 1'b0;
    pc = a;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (inst_mem_out_valid) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: pc 0x%08h never requested memory", a);
    end
  endtask

  task automatic do_abort(input logic [31:0] a, input logic [31:0] prev_instr);
    bit ok;
    start_until_req(a, ok);
    inst_mem_out_ready = 1'b1;
    inst_mem_out_data  = 32'h0BAD_0BAD;
    fetcher_reset      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inst_mem_out_ready = 1'b0;
    check("abort_valid", {31'd0, inst_mem_out_valid}, 32'd0);
    check("abort_instr", instruction, prev_instr);
    check("abort_hits", hit_count, exp_h);
    check("abort_misses", miss_count, exp_m);
  endtask

  task automatic do_async_reset(input logic [31:0] a);
    bit ok;
    start_until_req(a, ok);
    #1 reset = 1'b1;
    #1;
    check("areset_valid", {31'd0, inst_mem_out_valid}, 32'd0);
    check("areset_completed", {31'd0, fetcher_completed}, 32'd0);
    check("areset_hits", hit_count, 32'd0);
    check("areset_misses", miss_count, 32'd0);
    check("areset_instr", instruction, 32'd0);
    exp_h = 0;
    exp_m = 0;
    fetcher_reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    fetcher_reset = 1'b1;
    pc = '0;
    cache_flush = 1'b0;
    inst_mem_out_data = '0;
    inst_mem_out_ready = 1'b0;
    #3;
    check("rst_instr", instruction, 32'd0);
    check("rst_addr", inst_mem_out_addr, 32'd0);
    check("rst_valid", {31'd0, inst_mem_out_valid}, 32'd0);
    check("rst_completed", {31'd0, fetcher_completed}, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_fetch(32'h0000_0100, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);  // cold miss
    do_fetch(32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b1, 1'b0);  // hit
    do_fetch(32'h0000_0140, 32'h1111_1111, 2, 1'b0, 1'b0);  // conflict evicts 0x100
    do_fetch(32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    check("conflict_misses", miss_count, 32'd3);

    do_abort(32'h0000_0208, 32'hDEAD_BEEF);
    do_fetch(32'h0000_0208, 32'h2222_2222, 1, 1'b0, 1'b0);  // abort left no fill
    do_fetch(32'h0000_0208, 32'h2222_2222, 0, 1'b1, 1'b0);

    @(negedge clk);
    cache_flush = 1'b1;
    @(negedge clk);
    cache_flush = 1'b0;
    do_fetch(32'h0000_0100, 32'h3333_3333, 2, 1'b0, 1'b0);  // flushed -> miss

    do_fetch(32'h0000_010C, 32'h4444_4444, 1, 1'b0, 1'b1);  // flush beats fill
    do_fetch(32'h0000_010C, 32'h5555_5555, 1, 1'b0, 1'b0);

    do_async_reset(32'h0000_0100);
    do_fetch(32'h0000_0100, 32'h6666_6666, 2, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
